sync_fifo: RTL and testbench

//  Single-clock, parametrised FIFO for same-domain buffering between pipeline stages.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/sync_fifo_if.sv | 22 ++
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/sync_fifo.sv | 129 ++++++++++++
 tb/tb_sync_fifo.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers: read-mode selector and the pointer wrap step
// used by every FIFO variant in this library.
package fifo_pkg;

   typedef enum logic {
      FIFO_MODE_STD,
      FIFO_MODE_FWFT
   } fifo_mode_e;

   // Advance a circular pointer; wraps with an explicit compare so any depth works.
   function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Valid/ready handshake bundle for the write and read sides of a FIFO.
// master = producer/consumer environment, slave = the FIFO itself.
interface sync_fifo_if #(
   parameter int WIDTH = 32
);
   logic             wr_valid;
   logic             wr_ready;
   logic [WIDTH-1:0] wr_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] rd_data;

   modport master (
      output wr_valid, wr_data, rd_ready,
      input  wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  wr_valid, wr_data, rd_ready,
      output wr_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module sync_fifo_mem #(
   parameter int  WIDTH  = 32,
   parameter int  DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: capture the word on an accepted write.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready handshake, occupancy and high-water
// tracking, programmable almost-full/almost-empty thresholds, synchronous
// clear and either first-word-fall-through or registered-read output.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int         WIDTH  = 32,
   parameter int         DEPTH  = 256,
   parameter fifo_mode_e MODE   = FIFO_MODE_FWFT,
   localparam int        ADDR_W = $clog2(DEPTH),
   localparam int        CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   sync_fifo_if.slave       bus,
   input  logic [CNT_W-1:0] af_level,
   input  logic [CNT_W-1:0] ae_level,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] max_count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty
);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CNT_W-1:0]  max_q;
   logic [CNT_W-1:0]  max_nxt;
   logic              wr_fire;
   logic              pop_fire;
   logic [WIDTH-1:0]  mem_rd_data;

   // Flags are plain compares on the registered count; thresholds may move freely.
   assign full         = (cnt_q == CNT_W'(DEPTH));
   assign empty        = (cnt_q == '0);
   assign almost_full  = (cnt_q >= af_level);
   assign almost_empty = (cnt_q <= ae_level);
   assign count        = cnt_q;
   assign max_count    = max_q;

   // Full refuses writes even if a pop happens in the same cycle; clear drops both.
   assign bus.wr_ready = !full;
   assign wr_fire      = bus.wr_valid && !full && !clear;
   assign pop_fire     = bus.rd_ready && !empty && !clear;

   // Next occupancy and high-water mark; clear wins over any transfer.
   always_comb begin
      cnt_nxt = cnt_q;
      max_nxt = max_q;
      if (clear) begin
         cnt_nxt = '0;
         max_nxt = '0;
      end else begin
         case ({wr_fire, pop_fire})
            2'b10:   cnt_nxt = cnt_q + CNT_W'(1);
            2'b01:   cnt_nxt = cnt_q - CNT_W'(1);
            default: cnt_nxt = cnt_q;
         endcase
         max_nxt = (cnt_nxt > max_q) ? cnt_nxt : max_q;
      end
   end

   // Pointer, occupancy and high-water registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         max_q  <= '0;
      end else begin
         cnt_q <= cnt_nxt;
         max_q <= max_nxt;
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_fire) begin
               wr_ptr <= ADDR_W'(ptr_next(32'(wr_ptr), DEPTH));
            end
            if (pop_fire) begin
               rd_ptr <= ADDR_W'(ptr_next(32'(rd_ptr), DEPTH));
            end
         end
      end
   end

   sync_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clock (clock),
      .we    (wr_fire),
      .waddr (wr_ptr),
      .wdata (bus.wr_data),
      .raddr (rd_ptr),
      .rdata (mem_rd_data)
   );

   if (MODE == FIFO_MODE_STD) begin : g_std
      logic             rd_vld_p1;
      logic [WIDTH-1:0] rd_data_p1;

      // ---- read stage p1: word popped last cycle is presented here ----
      // Registered read: valid pulses for one cycle per pop, data holds otherwise.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
         end else begin
            rd_vld_p1 <= pop_fire;
            if (pop_fire) begin
               rd_data_p1 <= mem_rd_data;
            end
         end
      end

      assign bus.rd_valid = rd_vld_p1;
      assign bus.rd_data  = rd_data_p1;
   end else begin : g_fwft
      // Head word falls through; gated to zero while empty so stale storage never shows.
      assign bus.rd_valid = !empty;
      assign bus.rd_data  = empty ? '0 : mem_rd_data;
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a table of per-cycle vectors for the FWFT
// DEPTH=4 instance, plus hand sequences for wrap (DEPTH=5), STD mode,
// threshold edges and asynchronous reset.
module tb_sync_fifo;
   import fifo_pkg::*;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   // Instance A: FWFT, DEPTH 4
   sync_fifo_if #(.WIDTH(8)) if_a ();
   logic       clr_a;
   logic [2:0] afl_a, ael_a, cnt_a, max_a;
   logic       full_a, empty_a, af_a, ae_a;

   sync_fifo #(.WIDTH(8), .DEPTH(4), .MODE(FIFO_MODE_FWFT)) u_a (
      .clock(clock), .reset_n(reset_n), .clear(clr_a), .bus(if_a),
      .af_level(afl_a), .ae_level(ael_a), .count(cnt_a), .max_count(max_a),
      .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a));

   // Instance B: FWFT, DEPTH 5 (non power of two)
   sync_fifo_if #(.WIDTH(8)) if_b ();
   logic       clr_b;
   logic [2:0] afl_b, ael_b, cnt_b, max_b;
   logic       full_b, empty_b, af_b, ae_b;

   sync_fifo #(.WIDTH(8), .DEPTH(5), .MODE(FIFO_MODE_FWFT)) u_b (
      .clock(clock), .reset_n(reset_n), .clear(clr_b), .bus(if_b),
      .af_level(afl_b), .ae_level(ael_b), .count(cnt_b), .max_count(max_b),
      .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b));

   // Instance C: STD, DEPTH 4
   sync_fifo_if #(.WIDTH(8)) if_c ();
   logic       clr_c;
   logic [2:0] afl_c, ael_c, cnt_c, max_c;
   logic       full_c, empty_c, af_c, ae_c;

   sync_fifo #(.WIDTH(8), .DEPTH(4), .MODE(FIFO_MODE_STD)) u_c (
      .clock(clock), .reset_n(reset_n), .clear(clr_c), .bus(if_c),
      .af_level(afl_c), .ae_level(ael_c), .count(cnt_c), .max_count(max_c),
      .full(full_c), .empty(empty_c), .almost_full(af_c), .almost_empty(ae_c));

   typedef struct {
      logic        wv;
      logic [7:0]  wd;
      logic        rr;
      logic        clr;
      logic [19:0] want;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;
   int   exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   // {count, full, empty, af, ae, max_count, rd_valid, rd_data, wr_ready}
   function automatic logic [19:0] st(int c, int f, int e, int af, int ae, int mx, int rv, int rd);
      return {3'(c), 1'(f), 1'(e), 1'(af), 1'(ae), 3'(mx), 1'(rv), 8'(rd), 1'(f == 0)};
   endfunction

   task automatic add(int wv, int wd, int rr, int clr,
                      int c, int f, int e, int af, int ae, int mx, int rv, int rd);
      vec_t v;
      v.wv   = 1'(wv);
      v.wd   = 8'(wd);
      v.rr   = 1'(rr);
      v.clr  = 1'(clr);
      v.want = st(c, f, e, af, ae, mx, rv, rd);
      vecs.push_back(v);
   endtask

   initial begin
      logic [19:0] act;

      if_a.wr_valid = 1'b0; if_a.wr_data = '0; if_a.rd_ready = 1'b0; clr_a = 1'b0;
      if_b.wr_valid = 1'b0; if_b.wr_data = '0; if_b.rd_ready = 1'b0; clr_b = 1'b0;
      if_c.wr_valid = 1'b0; if_c.wr_data = '0; if_c.rd_ready = 1'b0; clr_c = 1'b0;
      afl_a = 3'd3; ael_a = 3'd1;
      afl_b = 3'd4; ael_b = 3'd1;
      afl_c = 3'd3; ael_c = 3'd1;

      // wv wd rr clr | count full empty af ae max rv rd
      add(1, 'h11, 0, 0,  1, 0, 0, 0, 1, 1, 1, 'h11);
      add(1, 'h22, 0, 0,  2, 0, 0, 0, 0, 2, 1, 'h11);
      add(1, 'h33, 0, 0,  3, 0, 0, 1, 0, 3, 1, 'h11);
      add(1, 'h44, 0, 0,  4, 1, 0, 1, 0, 4, 1, 'h11);
      add(1, 'h55, 0, 0,  4, 1, 0, 1, 0, 4, 1, 'h11);
      add(0, 0,    1, 0,  3, 0, 0, 1, 0, 4, 1, 'h22);
      add(0, 0,    1, 0,  2, 0, 0, 0, 0, 4, 1, 'h33);
      add(0, 0,    1, 0,  1, 0, 0, 0, 1, 4, 1, 'h44);
      add(0, 0,    1, 0,  0, 0, 1, 0, 1, 4, 0, 0);
      add(1, 'h01, 0, 0,  1, 0, 0, 0, 1, 4, 1, 'h01);
      add(1, 'h02, 0, 0,  2, 0, 0, 0, 0, 4, 1, 'h01);
      add(1, 'h03, 1, 0,  2, 0, 0, 0, 0, 4, 1, 'h02);
      add(1, 'h04, 1, 0,  2, 0, 0, 0, 0, 4, 1, 'h03);
      add(1, 'h05, 1, 0,  2, 0, 0, 0, 0, 4, 1, 'h04);
      add(1, 'h06, 1, 0,  2, 0, 0, 0, 0, 4, 1, 'h05);
      add(1, 'h07, 1, 0,  2, 0, 0, 0, 0, 4, 1, 'h06);
      add(0, 0,    1, 0,  1, 0, 0, 0, 1, 4, 1, 'h07);
      add(0, 0,    1, 0,  0, 0, 1, 0, 1, 4, 0, 0);
      add(1, 'h08, 1, 0,  1, 0, 0, 0, 1, 4, 1, 'h08);
      add(1, 'h09, 0, 0,  2, 0, 0, 0, 0, 4, 1, 'h08);
      add(1, 'h0A, 0, 0,  3, 0, 0, 1, 0, 4, 1, 'h08);
      add(1, 'hAA, 0, 1,  0, 0, 1, 0, 1, 0, 0, 0);
      add(0, 0,    1, 0,  0, 0, 1, 0, 1, 0, 0, 0);
      add(1, 'h5A, 0, 0,  1, 0, 0, 0, 1, 1, 1, 'h5A);
      add(0, 0,    1, 0,  0, 0, 1, 0, 1, 1, 0, 0);

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      act = {cnt_a, full_a, empty_a, af_a, ae_a, max_a, if_a.rd_valid, if_a.rd_data, if_a.wr_ready};
      check("reset_a", 32'(act), 32'(st(0, 0, 1, 0, 1, 0, 0, 0)));
      afl_a = 3'd0;
      #1;
      check("reset_af_lvl0", 32'(af_a), 32'd1);
      afl_a = 3'd3;
      #1;
      check("reset_std", 32'({if_c.rd_valid, if_c.rd_data, empty_c, cnt_c}), 32'({1'b0, 8'h00, 1'b1, 3'd0}));
      reset_n = 1'b1;

      // Table-driven FWFT vectors
      for (int i = 0; i < vecs.size(); i++) begin
         if_a.wr_valid = vecs[i].wv;
         if_a.wr_data  = vecs[i].wd;
         if_a.rd_ready = vecs[i].rr;
         clr_a         = vecs[i].clr;
         cycle();
         act = {cnt_a, full_a, empty_a, af_a, ae_a, max_a, if_a.rd_valid, if_a.rd_data, if_a.wr_ready};
         check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].want));
      end
      if_a.wr_valid = 1'b0; if_a.rd_ready = 1'b0; clr_a = 1'b0;

      // Threshold edges on a full FIFO
      for (int i = 0; i < 4; i++) begin
         if_a.wr_valid = 1'b1;
         if_a.wr_data  = 8'(8'hC0 + i);
         cycle();
      end
      if_a.wr_valid = 1'b0;
      check("fill_full", 32'({full_a, cnt_a}), 32'({1'b1, 3'd4}));
      afl_a = 3'd5;
      #1;
      check("af_above_depth", 32'(af_a), 32'd0);
      afl_a = 3'd4;
      #1;
      check("af_at_depth", 32'(af_a), 32'd1);
      afl_a = 3'd3;

      // DEPTH=5 wrap: prefill 3, then write+pop 4..12, then drain
      for (int v = 1; v <= 3; v++) begin
         if_b.wr_valid = 1'b1;
         if_b.wr_data  = 8'(v);
         cycle();
         exp_q.push_back(v);
      end
      for (int v = 4; v <= 12; v++) begin
         check($sformatf("d5_head%0d", v), 32'(if_b.rd_data), 32'(exp_q[0]));
         if_b.wr_valid = 1'b1;
         if_b.wr_data  = 8'(v);
         if_b.rd_ready = 1'b1;
         cycle();
         void'(exp_q.pop_front());
         exp_q.push_back(v);
         check($sformatf("d5_cnt%0d", v), 32'(cnt_b), 32'd3);
      end
      if_b.wr_valid = 1'b0;
      while (exp_q.size() > 0) begin
         check("d5_drain", 32'({if_b.rd_valid, if_b.rd_data}), 32'({1'b1, 8'(exp_q[0])}));
         if_b.rd_ready = 1'b1;
         cycle();
         void'(exp_q.pop_front());
      end
      if_b.rd_ready = 1'b0;
      check("d5_empty", 32'({empty_b, max_b}), 32'({1'b1, 3'd3}));

      // STD mode: registered read
      if_c.wr_valid = 1'b1; if_c.wr_data = 8'h77;
      cycle();
      if_c.wr_valid = 1'b0;
      check("std_wr", 32'({cnt_c, if_c.rd_valid}), 32'({3'd1, 1'b0}));
      if_c.rd_ready = 1'b1;
      cycle();
      check("std_pop", 32'({if_c.rd_valid, if_c.rd_data, empty_c}), 32'({1'b1, 8'h77, 1'b1}));
      cycle();
      check("std_nopop", 32'({if_c.rd_valid, if_c.rd_data}), 32'({1'b0, 8'h77}));
      if_c.rd_ready = 1'b0;
      if_c.wr_valid = 1'b1; if_c.wr_data = 8'h81;
      cycle();
      if_c.wr_data = 8'h82;
      cycle();
      if_c.wr_valid = 1'b0;
      if_c.rd_ready = 1'b1;
      cycle();
      check("std_b2b_1", 32'({if_c.rd_valid, if_c.rd_data}), 32'({1'b1, 8'h81}));
      cycle();
      check("std_b2b_2", 32'({if_c.rd_valid, if_c.rd_data}), 32'({1'b1, 8'h82}));
      if_c.rd_ready = 1'b0;
      cycle();
      check("std_idle", 32'({if_c.rd_valid, if_c.rd_data, cnt_c}), 32'({1'b0, 8'h82, 3'd0}));

      // Asynchronous reset mid-transfer on the full FWFT instance
      if_a.wr_valid = 1'b1; if_a.wr_data = 8'hEE; if_a.rd_ready = 1'b1;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("async_rst", 32'({cnt_a, empty_a, full_a, if_a.rd_valid, max_a}),
            32'({3'd0, 1'b1, 1'b0, 1'b0, 3'd0}));
      cycle();
      check("rst_hold", 32'({cnt_a, empty_a, if_a.wr_ready}), 32'({3'd0, 1'b1, 1'b1}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
